uart_rx: RTL



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_if.sv | 18 +
 rtl/uart_rx_sync2.sv | 22 ++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM encoding and bit-timing helper.
package uart_pkg;

    // Receiver FSM states; BREAK absorbs a line held low after a bad stop bit.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // Clocks per bit period, truncating integer division (12 MHz / 115200 = 104).
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input; resets to 1.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops; preset high so reset looks idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, one-entry holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 12000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     serial_rxd,
    uart_rx_if.master rx,
    output logic     frame_err,
    output logic     overrun,
    output logic     busy
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int          CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       rst_pipe;
    logic             rst_n_int;
    logic             rxd_s;
    logic             rxd_prev;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             deliver;
    logic             stop_err;

    // Reset asserts immediately but releases two clocks later, clean of clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n_int = rst_pipe[1];

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n_int),
        .d     (serial_rxd),
        .q     (rxd_s)
    );

    // Registered copy of the synchronized line for start-edge detection.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rxd_prev <= 1'b1;
        end else begin
            rxd_prev <= rxd_s;
        end
    end

    // FSM and datapath registers.
    // NOTE: every register here takes <= so all flops update from the same
    // pre-edge values; blocking '=' would make results depend on statement order.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic: bit timing, sampling and frame decisions.
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        deliver   = 1'b0;
        stop_err  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rxd_prev && !rxd_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    // A line back high by mid start bit was only a glitch.
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxd_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    // Leave at mid stop bit so a following start edge is not missed.
                    cnt_d = '0;
                    if (rxd_s) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_err = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_BREAK: begin
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register, handshake and one-cycle status pulses.
    // NOTE: all outputs reset explicitly so nothing, including a partial byte,
    // leaks out of an aborted frame.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rx.rx_data  <= 8'h00;
            rx.rx_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_err <= stop_err;
            overrun   <= deliver && rx.rx_valid && !rx.rx_ready;
            if (deliver && (!rx.rx_valid || rx.rx_ready)) begin
                // Load wins over accept, so a same-cycle accept has no valid gap.
                rx.rx_data  <= shift_q;
                rx.rx_valid <= 1'b1;
            end else if (rx.rx_valid && rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule
